// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: uDLX prefetch-queue fetch stage with redirect flush and in-flight discard.
// Define FETCH_PERF_CNT_EN to add perf_drop_cnt_out / perf_stall_cnt_out saturating counters.
module fetch_queue_unit #(
    parameter int PC_DATA_WIDTH = 20,
    parameter int INST_DATA_WIDTH = 32,
    parameter int INST_ADDR_WIDTH = 20,
    parameter logic [PC_DATA_WIDTH-1:0] PC_INITIAL_ADDRESS = '0,
    parameter int PC_INCREMENT = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       clk_en_in,
    input  logic                       select_new_pc_in,
    input  logic [PC_DATA_WIDTH-1:0]   new_pc_in,
    output logic                       inst_mem_req_out,
    output logic [INST_ADDR_WIDTH-1:0] inst_mem_addr_out,
    input  logic                       inst_mem_gnt_in,
    input  logic                       inst_mem_valid_in,
    input  logic [INST_DATA_WIDTH-1:0] inst_mem_data_in,
    output logic                       instruction_valid_out,
    input  logic                       instruction_ready_in,
    output logic [INST_DATA_WIDTH-1:0] instruction_reg_out,
    output logic [PC_DATA_WIDTH-1:0]   pc_out,
    output logic [PC_DATA_WIDTH-1:0]   new_pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                perf_drop_cnt_out,
    output logic [31:0]                perf_stall_cnt_out
`endif
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_DATA_WIDTH-1:0] PC_STEP = PC_DATA_WIDTH'(PC_INCREMENT);

    logic [PC_DATA_WIDTH-1:0] fetch_pc, resp_pc;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, outstanding, drop_cnt;
    logic [INST_DATA_WIDTH-1:0] inst_mem [QUEUE_DEPTH];
    logic [PC_DATA_WIDTH-1:0] pc_mem [QUEUE_DEPTH];
    logic grant, resp, discard, push, pop;

    always_comb begin
        inst_mem_req_out = !rst_in && clk_en_in && !select_new_pc_in &&
                           outstanding < CW'(MAX_OUTSTANDING) &&
                           ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(QUEUE_DEPTH);
        inst_mem_addr_out = rst_in ? '0 : fetch_pc[INST_ADDR_WIDTH-1:0];
        grant = inst_mem_req_out && inst_mem_gnt_in;
        resp = inst_mem_valid_in && outstanding != '0;
        discard = resp && (drop_cnt != '0 || select_new_pc_in);
        push = resp && !discard;
        instruction_valid_out = count != '0;
        pop = instruction_valid_out && instruction_ready_in && clk_en_in && !select_new_pc_in;
        instruction_reg_out = instruction_valid_out ? inst_mem[rd_ptr] : '0;
        pc_out = instruction_valid_out ? pc_mem[rd_ptr] : '0;
        new_pc_out = instruction_valid_out ? pc_mem[rd_ptr] + PC_STEP : '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fetch_pc <= PC_INITIAL_ADDRESS;
            resp_pc <= PC_INITIAL_ADDRESS;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            outstanding <= '0;
            drop_cnt <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(resp);
            if (select_new_pc_in) begin
                fetch_pc <= new_pc_in;
                resp_pc <= new_pc_in;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
                // every reply still in flight after this edge is stale; older pending drops are among them
                drop_cnt <= outstanding + CW'(grant) - CW'(resp);
            end else begin
                if (grant) fetch_pc <= fetch_pc + PC_STEP;
                if (push) begin
                    resp_pc <= resp_pc + PC_STEP;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
                drop_cnt <= drop_cnt - CW'(discard);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[wr_ptr] <= inst_mem_data_in;
            pc_mem[wr_ptr] <= resp_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_drop_cnt_out <= '0;
            perf_stall_cnt_out <= '0;
        end else begin
            if (discard && perf_drop_cnt_out != '1) perf_drop_cnt_out <= perf_drop_cnt_out + 32'd1;
            if (!instruction_valid_out && clk_en_in && perf_stall_cnt_out != '1)
                perf_stall_cnt_out <= perf_stall_cnt_out + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: scoreboard bench for fetch_queue_unit with a variable-latency in-order memory model.
module tb_fetch_queue_unit;
    logic        clk_in = 0, rst_in = 1, clk_en_in = 1, select_new_pc_in = 0;
    logic [19:0] new_pc_in = '0;
    logic        inst_mem_req_out;
    logic [19:0] inst_mem_addr_out;
    logic        inst_mem_gnt_in = 0, inst_mem_valid_in = 0;
    logic [31:0] inst_mem_data_in = '0;
    logic        instruction_valid_out, instruction_ready_in = 1;
    logic [31:0] instruction_reg_out;
    logic [19:0] pc_out, new_pc_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_drop_cnt_out, perf_stall_cnt_out;
`endif

    typedef struct { logic [19:0] pc; int due; bit live; } req_t;
    req_t        inflight[$];
    logic [19:0] exp_q[$];
    logic [19:0] exp_fetch = '0, redir_pc = '0;
    bit          check_redir = 0, rand_gnt = 0, spur = 0;
    int          cyc = 0, lat = 1, dropped = 0, stalls = 0, checks = 0, failures = 0;

    fetch_queue_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .clk_en_in(clk_en_in),
        .select_new_pc_in(select_new_pc_in), .new_pc_in(new_pc_in),
        .inst_mem_req_out(inst_mem_req_out), .inst_mem_addr_out(inst_mem_addr_out),
        .inst_mem_gnt_in(inst_mem_gnt_in), .inst_mem_valid_in(inst_mem_valid_in),
        .inst_mem_data_in(inst_mem_data_in), .instruction_valid_out(instruction_valid_out),
        .instruction_ready_in(instruction_ready_in), .instruction_reg_out(instruction_reg_out),
        .pc_out(pc_out), .new_pc_out(new_pc_out)
`ifdef FETCH_PERF_CNT_EN
        , .perf_drop_cnt_out(perf_drop_cnt_out), .perf_stall_cnt_out(perf_stall_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] tag(input logic [19:0] pc);
        return {12'hC0D, pc};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    // one cycle: drive memory side, sample mid-cycle, update the model, then cross the edge
    task automatic tick();
        req_t r;
        logic [19:0] e, np;
        bit exp_req;
        inst_mem_valid_in = 0;
        inst_mem_data_in = '0;
        if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            inst_mem_valid_in = 1;
            inst_mem_data_in = tag(inflight[0].pc);
        end else if (spur && inflight.size() == 0) begin
            inst_mem_valid_in = 1;
            inst_mem_data_in = 32'hDEAD_BEEF;
        end
        inst_mem_gnt_in = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        exp_req = clk_en_in && !select_new_pc_in && inflight.size() < 2 &&
                  exp_q.size() + inflight.size() < 4;
        check("req", {31'd0, inst_mem_req_out}, {31'd0, exp_req});
        check("valid", {31'd0, instruction_valid_out}, {31'd0, exp_q.size() != 0});
        if (inst_mem_req_out) check("addr", {12'd0, inst_mem_addr_out}, {12'd0, exp_fetch});
        if (clk_en_in && exp_q.size() == 0) stalls++;
        if (exp_q.size() != 0 && instruction_ready_in && clk_en_in && !select_new_pc_in) begin
            e = exp_q.pop_front();
            np = e + 20'd2;
            check("pc", {12'd0, pc_out}, {12'd0, e});
            check("inst", instruction_reg_out, tag(e));
            check("new_pc", {12'd0, new_pc_out}, {12'd0, np});
            if (check_redir) begin
                check("redir_head", {12'd0, pc_out}, {12'd0, redir_pc});
                check_redir = 0;
            end
        end
        if (inst_mem_valid_in && inflight.size() > 0) begin
            r = inflight.pop_front();
            if (r.live && !select_new_pc_in) exp_q.push_back(r.pc);
            else dropped++;
        end
        if (exp_req && inst_mem_gnt_in) begin
            inflight.push_back('{exp_fetch, cyc + lat, 1'b1});
            exp_fetch = exp_fetch + 20'd2;
        end
        if (select_new_pc_in) begin
            foreach (inflight[i]) inflight[i].live = 0;
            exp_q.delete();
            exp_fetch = new_pc_in;
            redir_pc = new_pc_in;
            check_redir = 1;
        end
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic redirect(input logic [19:0] target);
        select_new_pc_in = 1;
        new_pc_in = target;
        tick();
        select_new_pc_in = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_req", {31'd0, inst_mem_req_out}, 32'd0);
        check("rst_addr", {12'd0, inst_mem_addr_out}, 32'd0);
        check("rst_valid", {31'd0, instruction_valid_out}, 32'd0);
        check("rst_inst", instruction_reg_out, 32'd0);
        check("rst_pc", {12'd0, pc_out}, 32'd0);
        check("rst_new_pc", {12'd0, new_pc_out}, 32'd0);
        rst_in = 0;
        repeat (12) tick();
        instruction_ready_in = 0;
        repeat (10) tick();
        check("full_req", {31'd0, inst_mem_req_out}, 32'd0);
        check("full_valid", {31'd0, instruction_valid_out}, 32'd1);
        instruction_ready_in = 1;
        repeat (8) tick();
        lat = 3;
        for (int i = 0; i < 20 && inflight.size() != 2; i++) tick();
        redirect(20'h100);
        repeat (10) tick();
`ifdef FETCH_PERF_CNT_EN
        check("perf_drop_redirect", perf_drop_cnt_out, 32'd2);
`endif
        for (int i = 0; i < 20 && inflight.size() != 2; i++) tick();
        clk_en_in = 0;
        repeat (5) tick();
        clk_en_in = 1;
        repeat (10) tick();
        rand_gnt = 1;
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            instruction_ready_in = 1'($urandom_range(0, 1));
            tick();
        end
        rand_gnt = 0;
        instruction_ready_in = 1;
        lat = 3;
        repeat (6) tick();
        redirect(20'h200);
        redirect(20'h300);
        repeat (12) tick();
        lat = 1;
        redirect(20'hFFFFE);
        repeat (8) tick();
        redirect(20'h40);
        clk_en_in = 0;
        repeat (5) tick();
        spur = 1;
        tick();
        spur = 0;
        repeat (3) tick();
        clk_en_in = 1;
        repeat (10) tick();
`ifdef FETCH_PERF_CNT_EN
        check("perf_drop_total", perf_drop_cnt_out, 32'(dropped));
        check("perf_stall_total", perf_stall_cnt_out, 32'(stalls));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
